// File: rtl/serial_mag_comp.sv
// rtl/serial_mag_comp.sv - LSB-first bit-serial magnitude comparator with one-hot L/E/G; SIGNED_CMP_EN selects two's complement
module serial_mag_comp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             L,
  output logic             E,
  output logic             G
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0]    cnt;
  logic             wl, we, wg;
  logic             nl, ne, ng;
  logic             load;
  logic             last;
  logic             bit_gt, bit_lt;

  assign last = (cnt == LAST);

  // Next-state decode; a load happens on any accepted start, including straight out of DONE
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Resolve the current bit pair; a differing bit overrides whatever the lower bits decided
  always_comb begin
    nl     = wl;
    ne     = we;
    ng     = wg;
    bit_gt = a_sr[0] & ~b_sr[0];
    bit_lt = ~a_sr[0] & b_sr[0];
`ifdef SIGNED_CMP_EN
    // The sign bit carries negative weight, so its ordering is reversed
    if (last) begin
      bit_gt = ~a_sr[0] & b_sr[0];
      bit_lt = a_sr[0] & ~b_sr[0];
    end
`endif
    if (bit_gt) begin
      nl = 1'b0;
      ne = 1'b0;
      ng = 1'b1;
    end else if (bit_lt) begin
      nl = 1'b1;
      ne = 1'b0;
      ng = 1'b0;
    end
  end

  // State, datapath and result registers; outputs only update on the final bit
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      cnt   <= '0;
      wl    <= 1'b0;
      we    <= 1'b0;
      wg    <= 1'b0;
      L     <= 1'b0;
      E     <= 1'b0;
      G     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        a_sr <= a_in;
        b_sr <= b_in;
        cnt  <= '0;
        wl   <= 1'b0;
        we   <= 1'b1;
        wg   <= 1'b0;
      end else if (state == RUN) begin
        a_sr <= {1'b0, a_sr[WIDTH-1:1]};
        b_sr <= {1'b0, b_sr[WIDTH-1:1]};
        wl   <= nl;
        we   <= ne;
        wg   <= ng;
        if (last) begin
          L <= nl;
          E <= ne;
          G <= ng;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_mag_comp.sv
// tb/tb_serial_mag_comp.sv - scoreboard bench for serial_mag_comp
module tb_serial_mag_comp;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy, done, L, E, G;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic last_rst = 1'b1;
  logic [2:0] prev_leg = 3'b000;

  typedef struct {
    logic [2:0] leg;
    int         due;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  serial_mag_comp #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .L(L), .E(E), .G(G)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    last_rst = reset;
  end

  function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SIGNED_CMP_EN
    if ($signed(a) < $signed(b)) return 3'b100;
    if ($signed(a) > $signed(b)) return 3'b001;
`else
    if (a < b) return 3'b100;
    if (a > b) return 3'b001;
`endif
    return 3'b010;
  endfunction

  // Scoreboard monitor: result value, one-hot and latency on done; hold otherwise
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d", cyc);
      end else begin
        e = sb.pop_front();
        if ({L, E, G} !== e.leg) begin
          errors++;
          $display("FAIL result LEG=%b expected %b", {L, E, G}, e.leg);
        end
        checks++;
        if (cyc !== e.due) begin
          errors++;
          $display("FAIL latency done_cyc=%0d expected %0d", cyc, e.due);
        end
        checks++;
        if ($countones({L, E, G}) !== 1) begin
          errors++;
          $display("FAIL onehot LEG=%b expected one-hot", {L, E, G});
        end
      end
    end else if (!last_rst) begin
      checks++;
      if ({L, E, G} !== prev_leg) begin
        errors++;
        $display("FAIL hold LEG=%b expected %b", {L, E, G}, prev_leg);
      end
    end
    prev_leg = {L, E, G};
  end

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{model(a, b), cyc + W});
    start = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 4 * W) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout pending=%0d expected 0", tag, sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    a_in  = 8'h33;
    b_in  = 8'h44;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({busy, done, L, E, G} !== 5'b0) begin
        errors++;
        $display("FAIL reset_state busy,done,LEG=%b expected 00000", {busy, done, L, E, G});
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_idle busy,done=%b expected 00", {busy, done});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_patterns();
    logic [W-1:0] pa[10] = '{8'hA5, 8'h01, 8'h80, 8'h00, 8'hFF, 8'h81, 8'h01, 8'h7F, 8'hFE, 8'h40};
    logic [W-1:0] pb[10] = '{8'hA5, 8'h02, 8'h7F, 8'hFF, 8'h00, 8'h80, 8'h80, 8'h7F, 8'hFF, 8'hC0};
    for (int i = 0; i < 10; i++) begin
      launch(pa[i], pb[i]);
      wait_drain("pattern");
    end
    for (int i = 0; i < 6; i++) begin
      launch(W'($urandom), W'($urandom));
      wait_drain("random");
    end
  endtask

  task automatic test_ignore_busy();
    launch(8'h12, 8'h34);
    repeat (2) @(posedge clk);
    #1;
    a_in  = 8'hFF;
    b_in  = 8'h00;
    start = 1'b1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_during_run busy=%b expected 1", busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain("ignore");
  endtask

  task automatic test_abort();
    launch(8'h55, 8'hAA);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    checks++;
    if ({busy, done, L, E, G} !== 5'b0) begin
      errors++;
      $display("FAIL abort_state busy,done,LEG=%b expected 00000", {busy, done, L, E, G});
    end
    reset = 1'b0;
    repeat (2 * W) begin
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++;
        $display("FAIL abort_idle busy,done=%b expected 00", {busy, done});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int k;
    a_in  = 8'h10;
    b_in  = 8'h0F;
    start = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    sb.push_back('{model(8'h10, 8'h0F), k + W});
    a_in = 8'h0F;
    b_in = 8'h10;
    for (int r = 0; r < 2; r++) begin
      repeat (W) begin
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b10) begin
          errors++;
          $display("FAIL b2b_run busy,done=%b expected 10", {busy, done});
        end
      end
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b01) begin
        errors++;
        $display("FAIL b2b_done busy,done=%b expected 01", {busy, done});
      end
      if (r == 0) begin
        @(posedge clk); #1;
        sb.push_back('{model(8'h0F, 8'h10), cyc + W});
        start = 1'b0;
      end
    end
    wait_drain("b2b");
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_ignore_busy();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
